// File: rtl/da_serial_tx_if.sv
// da_serial_tx_if
//   Handshake and serial-lane bundle for the DA bit-serial transmitter.
//   Upstream side: x_in0..2, x_valid -> x_ready.
//   Downstream side: ser_hold -> ser_x0..2, ser_valid, ser_first, ser_last.
//   Status: busy.
//   Modports:
//     slave  - the transmitter itself
//     master - whoever drives samples and consumes the serial lanes
interface da_serial_tx_if #(
  parameter int W = 4
);
  logic signed [W-1:0] x_in0;
  logic signed [W-1:0] x_in1;
  logic signed [W-1:0] x_in2;
  logic                x_valid;
  logic                x_ready;
  logic                ser_hold;
  logic                ser_x0;
  logic                ser_x1;
  logic                ser_x2;
  logic                ser_valid;
  logic                ser_first;
  logic                ser_last;
  logic                busy;

  modport slave (
    input  x_in0, x_in1, x_in2, x_valid, ser_hold,
    output x_ready, ser_x0, ser_x1, ser_x2, ser_valid, ser_first, ser_last, busy
  );

  modport master (
    output x_in0, x_in1, x_in2, x_valid, ser_hold,
    input  x_ready, ser_x0, ser_x1, ser_x2, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/da_serial_tx.sv
// da_serial_tx
//   Bit-serial transmitter feeding a distributed-arithmetic inner-product
//   core. Sample triples are buffered in a 2-entry FIFO and sent LSB-first
//   on three parallel lanes, with frame-start (ser_first) and sign-bit
//   (ser_last) markers, followed by GAP idle cycles.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high
//     bus    - da_serial_tx_if.slave (sample handshake, serial lanes, busy)
//   Parameters:
//     W   - sample width, 2..16
//     GAP - idle cycles after each frame, 0..7
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting; loads FIFO head when non-empty and not held
//   S_SHIFT | presenting bits 1..W-1 of the loaded frame
//   S_GAP   | inter-frame idle, counts down GAP cycles ignoring ser_hold
module da_serial_tx #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  da_serial_tx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int         FW   = 3 * W;
  localparam logic [4:0] LAST = 5'(W - 1);

  state_t        r_state;
  logic [FW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;
  logic [W-1:0]  r_sh0;
  logic [W-1:0]  r_sh1;
  logic [W-1:0]  r_sh2;
  logic [4:0]    r_idx;
  logic [2:0]    r_gap;
  logic          r_ser_x0;
  logic          r_ser_x1;
  logic          r_ser_x2;
  logic          r_ser_valid;
  logic          r_ser_first;
  logic          r_ser_last;

  logic          w_push;
  logic          w_pop;
  logic [FW-1:0] w_head;
  logic [W-1:0]  w_h0;
  logic [W-1:0]  w_h1;
  logic [W-1:0]  w_h2;

  assign bus.x_ready = (r_count < 2'd2);
  assign w_push      = bus.x_valid & bus.x_ready;
  // Load condition doubles as the FIFO pop; no bypass, so a word pushed
  // this edge is not visible to the load until the next edge.
  assign w_pop       = (r_state == S_IDLE) & (r_count != 2'd0) & ~bus.ser_hold;
  assign w_head      = r_mem[r_rptr];
  assign w_h0        = w_head[W-1:0];
  assign w_h1        = w_head[2*W-1:W];
  assign w_h2        = w_head[3*W-1:2*W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {bus.x_in2, bus.x_in1, bus.x_in0};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_gap       <= 3'd0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_sh2       <= '0;
      r_ser_x0    <= 1'b0;
      r_ser_x1    <= 1'b0;
      r_ser_x2    <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      // Markers are only ever high alongside a presented bit; data bits
      // keep their last value whenever nothing is presented.
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_ser_x0    <= w_h0[0];
            r_ser_x1    <= w_h1[0];
            r_ser_x2    <= w_h2[0];
            r_ser_valid <= 1'b1;
            r_ser_first <= 1'b1;
            r_sh0       <= w_h0 >> 1;
            r_sh1       <= w_h1 >> 1;
            r_sh2       <= w_h2 >> 1;
            r_idx       <= 5'd1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bus.ser_hold) begin
            r_ser_x0    <= r_sh0[0];
            r_ser_x1    <= r_sh1[0];
            r_ser_x2    <= r_sh2[0];
            r_ser_valid <= 1'b1;
            r_sh0       <= r_sh0 >> 1;
            r_sh1       <= r_sh1 >> 1;
            r_sh2       <= r_sh2 >> 1;
            r_idx       <= r_idx + 5'd1;
            if (r_idx == LAST) begin
              r_ser_last <= 1'b1;
              r_idx      <= 5'd0;
              // With no gap, returning to IDLE lets the next frame load on
              // the very next edge, giving contiguous frames.
              if (GAP > 0) begin
                r_state <= S_GAP;
                r_gap   <= 3'(GAP);
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_GAP: begin
          r_gap <= r_gap - 3'd1;
          if (r_gap == 3'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ser_x0    = r_ser_x0;
  assign bus.ser_x1    = r_ser_x1;
  assign bus.ser_x2    = r_ser_x2;
  assign bus.ser_valid = r_ser_valid;
  assign bus.ser_first = r_ser_first;
  assign bus.ser_last  = r_ser_last;
  assign bus.busy      = (r_state != S_IDLE) | (r_count != 2'd0);

endmodule

// File: tb/tb_da_serial_tx.sv
// tb_da_serial_tx
//   Two transmitters (GAP=1 and GAP=0, W=4) against a frame-level model:
//   a word list for the FIFO, a "frame in flight" with next bit position,
//   and a remaining-gap count. Outputs are compared on every falling edge;
//   directed scenarios add literal expectations on the logged bit stream.
module tb_da_serial_tx;
  localparam int W    = 4;
  localparam int FW   = 3 * W;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [2];
  logic         xv   [2];
  logic         hold [2];
  logic [W-1:0] xin  [2][3];

  da_serial_tx_if #(.W(W)) if0 ();
  da_serial_tx_if #(.W(W)) if1 ();

  assign if0.x_valid  = xv[0];
  assign if0.x_in0    = xin[0][0];
  assign if0.x_in1    = xin[0][1];
  assign if0.x_in2    = xin[0][2];
  assign if0.ser_hold = hold[0];
  assign if1.x_valid  = xv[1];
  assign if1.x_in0    = xin[1][0];
  assign if1.x_in1    = xin[1][1];
  assign if1.x_in2    = xin[1][2];
  assign if1.ser_hold = hold[1];

  da_serial_tx #(.W(W), .GAP(1)) dut0 (.clk(clk), .reset(rst[0]), .bus(if0));
  da_serial_tx #(.W(W), .GAP(0)) dut1 (.clk(clk), .reset(rst[1]), .bus(if1));

  logic       o_rdy [2], o_busy [2], o_v [2], o_f [2], o_l [2];
  logic [2:0] o_x   [2];
  assign o_rdy[0]  = if0.x_ready;
  assign o_busy[0] = if0.busy;
  assign o_v[0]    = if0.ser_valid;
  assign o_f[0]    = if0.ser_first;
  assign o_l[0]    = if0.ser_last;
  assign o_x[0]    = {if0.ser_x2, if0.ser_x1, if0.ser_x0};
  assign o_rdy[1]  = if1.x_ready;
  assign o_busy[1] = if1.busy;
  assign o_v[1]    = if1.ser_valid;
  assign o_f[1]    = if1.ser_first;
  assign o_l[1]    = if1.ser_last;
  assign o_x[1]    = {if1.ser_x2, if1.ser_x1, if1.ser_x0};

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [FW-1:0] mq   [2][2];
  int            msz  [2];
  logic [FW-1:0] cur  [2];
  bit            act  [2];
  int            mbit [2];
  int            gleft[2];
  logic          e_v  [2], e_f [2], e_l [2];
  logic [2:0]    e_x  [2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic emit(input int k);
    int b;
    b = mbit[k];
    e_x[k] = {cur[k][2*W+b], cur[k][W+b], cur[k][b]};
    e_v[k] = 1'b1;
    e_f[k] = (b == 0);
    e_l[k] = (b == W - 1);
    mbit[k] = b + 1;
    if (mbit[k] == W) begin
      act[k]   = 1'b0;
      gleft[k] = gap_of(k);
    end
  endtask

  task automatic model_step(input int k);
    logic          push;
    logic [FW-1:0] w;
    if (rst[k]) begin
      msz[k] = 0; act[k] = 1'b0; mbit[k] = 0; gleft[k] = 0;
      e_v[k] = 1'b0; e_f[k] = 1'b0; e_l[k] = 1'b0; e_x[k] = 3'b000;
      return;
    end
    push = xv[k] && (msz[k] < 2);
    w    = {xin[k][2], xin[k][1], xin[k][0]};
    e_v[k] = 1'b0; e_f[k] = 1'b0; e_l[k] = 1'b0;
    if (act[k]) begin
      if (!hold[k]) emit(k);
    end else if (gleft[k] > 0) begin
      gleft[k] = gleft[k] - 1;
    end else if (msz[k] > 0 && !hold[k]) begin
      cur[k]   = mq[k][0];
      mq[k][0] = mq[k][1];
      msz[k]   = msz[k] - 1;
      mbit[k]  = 0;
      act[k]   = 1'b1;
      emit(k);
    end
    if (push) begin
      mq[k][msz[k]] = w;
      msz[k] = msz[k] + 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      msz[k] = 0; act[k] = 1'b0; mbit[k] = 0; gleft[k] = 0;
      e_v[k] = 1'b0; e_f[k] = 1'b0; e_l[k] = 1'b0; e_x[k] = 3'b000;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- compare + log ----------------
  logic [2:0] lg_x   [2][LOGN];
  logic       lg_f   [2][LOGN];
  logic       lg_l   [2][LOGN];
  int         lg_cyc [2][LOGN];
  int         lg_n   [2];

  initial begin
    lg_n[0] = 0;
    lg_n[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid[%0d]", k), o_v[k], e_v[k]);
        chk($sformatf("first[%0d]", k), o_f[k], e_f[k]);
        chk($sformatf("last[%0d]", k),  o_l[k], e_l[k]);
        chk($sformatf("ready[%0d]", k), o_rdy[k], (msz[k] < 2));
        chk($sformatf("busy[%0d]", k),  o_busy[k], (act[k] || gleft[k] > 0 || msz[k] > 0));
        if (e_v[k]) chk($sformatf("bits[%0d]", k), o_x[k], e_x[k]);
        if (o_v[k] === 1'b1 && lg_n[k] < LOGN) begin
          lg_x[k][lg_n[k]]   = o_x[k];
          lg_f[k][lg_n[k]]   = o_f[k];
          lg_l[k][lg_n[k]]   = o_l[k];
          lg_cyc[k][lg_n[k]] = cyc;
          lg_n[k]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input int k, input int a, input int b, input int c);
    logic [W-1:0] t;
    xv[k] = 1'b1;
    t = W'(a); xin[k][0] = t;
    t = W'(b); xin[k][1] = t;
    t = W'(c); xin[k][2] = t;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (o_busy[k] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_reached[%0d]", k), o_busy[k], 1'b0);
  endtask

  int  base, d, sent, n_after, guard;
  bit  saw_full, acc;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; xv[k] = 1'b0; hold[k] = 1'b0;
      for (int j = 0; j < 3; j++) xin[k][j] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_valid", o_v[0], 1'b0);
    chk("reset_ready", o_rdy[0], 1'b1);
    chk("reset_busy",  o_busy[0], 1'b0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // single frame 5,-3,-8 on GAP=1
    wait_idle(0);
    base = lg_n[0]; d = cyc;
    put(0, 5, -3, -8);
    @(negedge clk); xv[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_nbits",  lg_n[0] - base, 4);
    chk("t1_latency", lg_cyc[0][base], d + 2);
    chk("t1_b0", lg_x[0][base],   3'b011);
    chk("t1_b1", lg_x[0][base+1], 3'b000);
    chk("t1_b2", lg_x[0][base+2], 3'b011);
    chk("t1_b3", lg_x[0][base+3], 3'b110);
    chk("t1_first", lg_f[0][base], 1'b1);
    chk("t1_last",  lg_l[0][base+3], 1'b1);
    chk("t1_contig", lg_cyc[0][base+3], d + 5);
    chk("t1_busy_end", o_busy[0], 1'b0);

    // burst of 4 held on x_valid
    wait_idle(0);
    base = lg_n[0]; sent = 0; saw_full = 1'b0; guard = 0;
    while (sent < 4 && guard < 100) begin
      put(0, int'($urandom), int'($urandom), int'($urandom));
      acc = o_rdy[0];
      if (!o_rdy[0]) saw_full = 1'b1;
      @(negedge clk);
      if (acc) sent++;
      guard++;
    end
    xv[0] = 1'b0;
    wait_idle(0);
    chk("t2_full_seen", saw_full, 1'b1);
    chk("t2_nbits", lg_n[0] - base, 16);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t2_period%0d", i), lg_cyc[0][base+4*i] - lg_cyc[0][base+4*(i-1)], 5);

    // GAP=0 back-to-back
    wait_idle(1);
    base = lg_n[1]; d = cyc;
    put(1, int'($urandom), int'($urandom), int'($urandom));
    @(negedge clk);
    put(1, int'($urandom), int'($urandom), int'($urandom));
    @(negedge clk); xv[1] = 1'b0;
    wait_idle(1);
    chk("t3_nbits", lg_n[1] - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_cyc%0d", i), lg_cyc[1][base+i], d + 2 + i);
      chk($sformatf("t3_first%0d", i), lg_f[1][base+i], (i % 4 == 0));
    end

    // hold for 3 cycles after bit 1 of frame 7,-1,0
    wait_idle(0);
    base = lg_n[0]; d = cyc;
    put(0, 7, -1, 0);
    @(negedge clk); xv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); hold[0] = 1'b1;
    repeat (3) @(negedge clk);
    hold[0] = 1'b0;
    wait_idle(0);
    chk("t4_nbits", lg_n[0] - base, 4);
    chk("t4_b1_cyc", lg_cyc[0][base+1], d + 3);
    chk("t4_b2_cyc", lg_cyc[0][base+2], d + 7);
    chk("t4_b3_cyc", lg_cyc[0][base+3], d + 8);
    chk("t4_b2", lg_x[0][base+2], 3'b011);
    chk("t4_b3", lg_x[0][base+3], 3'b010);

    // reset mid-frame with one word queued
    wait_idle(0);
    base = lg_n[0];
    put(0, 3, 4, 5);
    @(negedge clk); put(0, 6, 7, 1);
    @(negedge clk); xv[0] = 1'b0;
    @(negedge clk); rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_valid", o_v[0], 1'b0);
    chk("t5_bits",  o_x[0], 3'b000);
    chk("t5_first", o_f[0], 1'b0);
    chk("t5_last",  o_l[0], 1'b0);
    chk("t5_ready", o_rdy[0], 1'b1);
    chk("t5_busy",  o_busy[0], 1'b0);
    rst[0] = 1'b0;
    n_after = lg_n[0];
    repeat (15) @(negedge clk);
    chk("t5_sent_before", n_after - base, 2);
    chk("t5_no_more", lg_n[0], n_after);

    // push and pop together with count==1 at end of gap
    wait_idle(0);
    base = lg_n[0]; d = cyc;
    put(0, 2, 2, 2);
    @(negedge clk); xv[0] = 1'b0;
    @(negedge clk); put(0, 1, 0, 1);
    @(negedge clk); xv[0] = 1'b0;
    repeat (3) @(negedge clk);
    put(0, 2, 3, 6);
    @(negedge clk); xv[0] = 1'b0;
    chk("t6_ready", o_rdy[0], 1'b1);
    chk("t6_busy",  o_busy[0], 1'b1);
    wait_idle(0);
    chk("t6_nbits", lg_n[0] - base, 12);
    chk("t6_b_cyc", lg_cyc[0][base+4], d + 7);
    chk("t6_c_cyc", lg_cyc[0][base+8], d + 12);
    chk("t6_b_bit0", lg_x[0][base+4], 3'b101);
    chk("t6_c_bit0", lg_x[0][base+8], 3'b010);

    // randomized traffic on both instances
    for (int it = 0; it < 2000; it++) begin
      for (int k = 0; k < 2; k++) begin
        xv[k]   = ($urandom_range(0, 9) < 6);
        hold[k] = ($urandom_range(0, 9) < 2);
        rst[k]  = ($urandom_range(0, 299) == 0);
        for (int j = 0; j < 3; j++) xin[k][j] = W'($urandom);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      xv[k] = 1'b0; hold[k] = 1'b0; rst[k] = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
    $fatal(1);
  end

endmodule
